// File: rtl/triple_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : triple_sweep_pkg
// Brief    : Shared widths, FSM encoding and tag record for triple_sweep.
// Revision : 1.0
// ============================================================================
package triple_sweep_pkg;

    localparam int IDX_W = 15;
    localparam int OPW   = 5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/hit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hit_fifo
// Brief    : Synchronous FIFO with flush; pointers carry one wrap bit.
// Revision : 1.0
// ============================================================================
module hit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign count     = r_wptr - r_rptr;
    assign empty     = (r_wptr == r_rptr);
    assign full      = (count == (c_aw+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/triple_sweep.sv
`default_nettype none
// ============================================================================
// Module   : triple_sweep
// Brief    : Sweeps all 5-bit (a,b,c) triples, counts sig hits, queues hits.
// Revision : 1.0
// ============================================================================
module triple_sweep
    import triple_sweep_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [OPW-1:0]   a,
    output logic [OPW-1:0]   b,
    output logic [OPW-1:0]   c,
    input  logic             sig,
    output logic [15:0]      hit_count,
    output logic             overflow,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [IDX_W-1:0] hit_data
);

    localparam logic [3:0] c_drain_last = 4'(LAT-1);

    logic [1:0]                    r_state;
    logic [1:0]                    w_next_state;
    logic [IDX_W-1:0]              r_idx;
    logic [3:0]                    r_drain;
    logic [15:0]                   r_hit_count;
    logic                          r_overflow;
    tag_t                          r_tag [LAT];

    logic                          w_start_sweep;
    logic                          w_last_idx;
    logic                          w_hit;
    logic                          w_pop;
    logic                          w_drop;
    logic                          w_full;
    logic                          w_empty;
    logic [$clog2(FIFO_DEPTH):0]   w_count;

    assign w_start_sweep = (r_state == IDLE) && start;
    assign w_last_idx    = (r_idx == '1);
    assign w_hit         = r_tag[LAT-1].valid && sig;
    assign w_pop         = hit_ready && !w_empty;
    assign w_drop        = w_hit && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SWEEP;
            SWEEP:   if (w_last_idx) w_next_state = DRAIN;
            DRAIN:   if (r_drain == c_drain_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SWEEP, DRAIN: busy = 1'b1;
            DONE:         done = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_drain     <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_start_sweep) begin
                r_idx       <= '0;
                r_hit_count <= '0;
                r_overflow  <= 1'b0;
            end else begin
                // idx parks on the last triple so there is no second pass.
                if (r_state == SWEEP && !w_last_idx) r_idx <= r_idx + IDX_W'(1);
                if (w_hit)  r_hit_count <= r_hit_count + 16'd1;
                if (w_drop) r_overflow  <= 1'b1;
            end
            r_drain <= (r_state == DRAIN) ? r_drain + 4'd1 : 4'd0;
        end
    end

    // Tag shift register: the last stage lines up with the sig of its triple.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= '{valid: (r_state == SWEEP), idx: r_idx};
            for (int i = LAT-1; i > 0; i--) r_tag[i] <= r_tag[i-1];
        end
    end

    hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_hit_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_start_sweep),
        .push  (w_hit),
        .pop   (w_pop),
        .din   (r_tag[LAT-1].idx),
        .dout  (hit_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign a         = r_idx[14:10];
    assign b         = r_idx[9:5];
    assign c         = r_idx[4:0];
    assign hit_count = r_hit_count;
    assign overflow  = r_overflow;
    assign hit_valid = (w_count != '0);

endmodule
`default_nettype wire
